// File: rtl/score_display_scanner.sv
// Three-digit multiplexed seven-segment scan controller with a one-entry
// pending score slot that is committed only at frame boundaries.

module score_digit_lane (
    input  logic       lit,
    input  logic       blank,
    input  logic [7:0] seg_in,
    output logic       en_n,
    output logic [7:0] seg
);
    assign en_n = ~lit;
    // Unlit lanes drive all-ones so the active-low bus can be AND-merged.
    assign seg  = (lit && !blank) ? seg_in : 8'hFF;
endmodule

module score_display_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       score_valid,
    input  logic [9:0] score_bcd,
    output logic       score_ready,
    input  logic       blank_leading,
    output logic [9:0] bcd_to_decoder,
    input  logic [7:0] hunds_seg_in,
    input  logic [7:0] tens_seg_in,
    input  logic [7:0] units_seg_in,
    output logic [7:0] seg_out,
    output logic [2:0] digit_en_n,
    output logic       frame_tick
);
    localparam int MAX_CNT = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    // Digit index doubles as the bit position in digit_en_n.
    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_HUNDS = 2'd2;

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t           state;
    logic [1:0]       digit;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       disp;
    logic [9:0]       pend;
    logic             pend_full;
    logic             xfer;
    logic             frame_end;
    logic [1:0]       next_digit;

    logic [2:0][7:0]  lane_seg_in;
    logic [2:0][7:0]  lane_seg;
    logic [2:0]       lane_lit;
    logic [2:0]       lane_blank;

    assign xfer       = score_valid && score_ready;
    assign frame_end  = (state == ST_SHOW) && (cnt == SHOW_LAST) && (digit == DIG_UNITS);
    assign next_digit = (digit == DIG_UNITS) ? DIG_HUNDS : digit - 2'd1;

    assign frame_tick     = frame_end;
    assign bcd_to_decoder = disp;

    assign lane_seg_in = {hunds_seg_in, tens_seg_in, units_seg_in};
    assign lane_blank  = {blank_leading && (disp[9:8] == 2'd0),
                          blank_leading && (disp[9:4] == 6'd0),
                          1'b0};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_lane
            assign lane_lit[i] = (state == ST_SHOW) && (digit == 2'(i));
            score_digit_lane u_lane (
                .lit    (lane_lit[i]),
                .blank  (lane_blank[i]),
                .seg_in (lane_seg_in[i]),
                .en_n   (digit_en_n[i]),
                .seg    (lane_seg[i])
            );
        end
    endgenerate

    assign seg_out = lane_seg[0] & lane_seg[1] & lane_seg[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_GUARD;
            digit       <= DIG_HUNDS;
            cnt         <= '0;
            disp        <= '0;
            pend        <= '0;
            pend_full   <= 1'b0;
            score_ready <= 1'b0;
        end else begin
            // Ready drops right after a transfer and returns one cycle after commit.
            score_ready <= ~pend_full & ~xfer;
            if (xfer) begin
                pend      <= score_bcd;
                pend_full <= 1'b1;
            end else if (frame_end && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end

            case (state)
                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                        digit <= next_digit;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_GUARD;
            endcase
        end
    end
endmodule

// File: tb/tb_score_display_scanner.sv
// Randomized scoreboard bench for score_display_scanner: a cycle-position
// reference model predicts the scan outputs, and a commit queue checks scores.

module tb_score_display_scanner;
    localparam int S    = 4;
    localparam int G    = 2;
    localparam int SLOT = S + G;
    localparam int F    = 3 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       score_valid = 1'b0;
    logic [9:0] score_bcd = '0;
    logic       score_ready;
    logic       blank_leading = 1'b0;
    logic [9:0] bcd_to_decoder;
    logic [7:0] hunds_seg_in = 8'h11;
    logic [7:0] tens_seg_in = 8'h22;
    logic [7:0] units_seg_in = 8'h33;
    logic [7:0] seg_out;
    logic [2:0] digit_en_n;
    logic       frame_tick;

    always #5 clk = ~clk;

    score_display_scanner #(.SCAN_DIV(S), .GUARD_CYCLES(G)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .score_valid    (score_valid),
        .score_bcd      (score_bcd),
        .score_ready    (score_ready),
        .blank_leading  (blank_leading),
        .bcd_to_decoder (bcd_to_decoder),
        .hunds_seg_in   (hunds_seg_in),
        .tens_seg_in    (tens_seg_in),
        .units_seg_in   (units_seg_in),
        .seg_out        (seg_out),
        .digit_en_n     (digit_en_n),
        .frame_tick     (frame_tick)
    );

    typedef struct {
        logic [9:0] val;
        int         cyc;
    } commit_t;

    commit_t    sbq[$];
    int         t = 0;
    int         total = 0;
    int         bad = 0;
    bit         armed = 1'b0;
    logic [9:0] m_disp = '0;
    logic [9:0] m_pend = '0;
    bit         m_full = 1'b0;
    bit         m_rdy = 1'b0;
    logic [9:0] prev_bcd = '0;
    logic [9:0] last_sent = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, t, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s cycle=%0d got=timeout want=event", nm, t);
    endtask

    // Reference model: t is the current cycle number since reset release.
    always @(posedge clk) begin
        bit xfer;
        bit nrdy;
        int nb;
        if (!rst_n) begin
            t = 0;
            m_disp = '0;
            m_pend = '0;
            m_full = 1'b0;
            m_rdy = 1'b0;
            sbq.delete();
        end else begin
            xfer = score_valid && m_rdy;
            nrdy = !m_full && !xfer;
            if ((t % F) == F - 1 && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
            end
            if (xfer) begin
                m_pend = score_bcd;
                m_full = 1'b1;
                nb = (t / F) * F + F - 1;
                if (nb == t) nb += F;
                sbq.push_back('{score_bcd, nb + 1});
            end
            m_rdy = nrdy;
            t++;
        end
    end

    // Monitor: per-cycle scan check plus commit scoreboard.
    always @(posedge clk) begin
        int pos;
        int dig;
        bit show;
        bit blk;
        logic [2:0] e_en;
        logic [7:0] e_seg;
        logic [7:0] sin;
        commit_t    e;
        #2;
        if (armed) begin
            pos  = t % F;
            show = (pos % SLOT) >= G;
            dig  = 2 - pos / SLOT;
            sin  = (dig == 2) ? hunds_seg_in : (dig == 1) ? tens_seg_in : units_seg_in;
            blk  = blank_leading && ((dig == 2 && m_disp[9:8] == 2'd0) ||
                                     (dig == 1 && m_disp[9:4] == 6'd0));
            e_en  = show ? ~(3'b001 << dig) : 3'b111;
            e_seg = (show && !blk) ? sin : 8'hFF;
            chk("digit_en_n", 32'(digit_en_n), 32'(e_en));
            chk("seg_out", 32'(seg_out), 32'(e_seg));
            chk("frame_tick", 32'(frame_tick), 32'(pos == F - 1));
            chk("score_ready", 32'(score_ready), 32'(m_rdy));
            chk("bcd_to_decoder", 32'(bcd_to_decoder), 32'(m_disp));
            if (!rst_n) begin
                prev_bcd = '0;
            end else if (bcd_to_decoder !== prev_bcd) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit cycle=%0d got=%0h want=%0h", t, bcd_to_decoder, prev_bcd);
                end else begin
                    e = sbq.pop_front();
                    chk("commit_value", 32'(bcd_to_decoder), 32'(e.val));
                    chk("commit_cycle", t, e.cyc);
                end
                prev_bcd = bcd_to_decoder;
            end
        end
    end

    // Decoder returns fresh patterns every cycle so seg_out routing is exercised.
    always @(negedge clk) begin
        if (armed) begin
            hunds_seg_in = 8'($urandom);
            tens_seg_in  = 8'($urandom);
            units_seg_in = 8'($urandom);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        score_valid = 1'b0;
        repeat (n) @(negedge clk);
        armed = 1'b1;
        last_sent = '0;
        rst_n = 1'b1;
    endtask

    task automatic wait_cycle(input int k);
        int n = 0;
        while (t != k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (t != k) fail_now("wait_cycle");
    endtask

    task automatic send(input logic [9:0] v);
        int n = 0;
        score_valid = 1'b1;
        score_bcd   = v;
        while (!score_ready && n < 4 * F) begin
            @(negedge clk);
            n++;
        end
        if (!score_ready) begin
            fail_now("send_ready");
            score_valid = 1'b0;
        end else begin
            @(negedge clk);
            score_valid = 1'b0;
            last_sent = v;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 4 * F) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        logic [9:0] v;
        do_reset(3);

        // Commit at frame boundary, then backpressure with a held valid.
        wait_cycle(5);
        send(10'h123);
        send(10'h045);
        send(10'h067);
        drain();

        // Leading-zero blanking.
        blank_leading = 1'b1;
        send(10'h005);
        drain();
        repeat (F) @(negedge clk);
        send(10'h100);
        drain();
        repeat (F) @(negedge clk);
        send(10'h010);
        drain();
        repeat (F) @(negedge clk);

        // Transfer on the frame-boundary edge with the slot empty.
        blank_leading = 1'b0;
        do_reset(2);
        wait_cycle(F - 1);
        send(10'h2a9);
        drain();

        // Reset mid-frame with the slot full discards the pending value.
        do_reset(2);
        wait_cycle(3);
        send(10'h321);
        wait_cycle(9);
        do_reset(1);
        repeat (2 * F) @(negedge clk);

        // Randomized traffic.
        repeat (25) begin
            repeat ($urandom_range(F, 0)) @(negedge clk);
            blank_leading = 1'($urandom);
            do begin
                v = {2'($urandom_range(3, 0)), 8'($urandom)};
            end while (v == last_sent);
            send(v);
        end
        drain();
        repeat (F) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
